// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline.
// Handles load-use hazards, MEM-stage redirects and data-memory waits with a timeout.
module pipe_hazard_ctrl #(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idex_memread,
    input  logic [4:0]       idex_dst,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_use_rt,
    input  logic             mem_redirect,
    input  logic             mem_access,
    input  logic             dmem_ready,
    input  logic             halt_req,
    output logic             PCW,
    output logic             IFIDW,
    output logic             IDEXW,
    output logic             EXMEMW,
    output logic             MEMWBW,
    output logic             rst1,
    output logic             rst2,
    output logic             rst3,
    output logic             rst4,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WC_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {
        RUN,
        MWAIT,
        HALT
    } state_t;

    state_t            r_state;
    logic [WC_W-1:0]   r_waitCnt;
    logic [CNT_W-1:0]  r_stallCnt;
    logic              r_memTimeout;

    logic w_freeze;
    logic w_loadUse;
    logic w_waitLimit;

    assign w_freeze    = mem_access & ~dmem_ready;
    assign w_loadUse   = idex_memread & (idex_dst != 5'd0) &
                         ((idex_dst == ifid_rs) | (ifid_use_rt & (idex_dst == ifid_rt)));
    assign w_waitLimit = (r_waitCnt == WC_W'(WAIT_MAX - 1));

    assign halted      = (r_state == HALT) & ~rst;
    assign mem_timeout = r_memTimeout;
    assign stall_cnt   = r_stallCnt;

    // Priority: freeze beats redirect beats load-use; HALT holds everything in place.
    always_comb begin
        PCW    = 1'b0;
        IFIDW  = 1'b0;
        IDEXW  = 1'b0;
        EXMEMW = 1'b0;
        MEMWBW = 1'b0;
        rst1   = 1'b0;
        rst2   = 1'b0;
        rst3   = 1'b0;
        rst4   = 1'b0;
        if (rst) begin
            rst1 = 1'b1;
            rst2 = 1'b1;
            rst3 = 1'b1;
            rst4 = 1'b1;
        end else if (r_state != HALT) begin
            if (w_freeze) begin
                rst4 = 1'b1;
            end else if (mem_redirect) begin
                PCW    = 1'b1;
                IFIDW  = 1'b1;
                IDEXW  = 1'b1;
                EXMEMW = 1'b1;
                MEMWBW = 1'b1;
                rst1   = 1'b1;
                rst2   = 1'b1;
                rst3   = 1'b1;
            end else if (w_loadUse) begin
                IDEXW  = 1'b1;
                EXMEMW = 1'b1;
                MEMWBW = 1'b1;
                rst2   = 1'b1;
            end else begin
                PCW    = 1'b1;
                IFIDW  = 1'b1;
                IDEXW  = 1'b1;
                EXMEMW = 1'b1;
                MEMWBW = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RUN;
            r_waitCnt    <= '0;
            r_stallCnt   <= '0;
            r_memTimeout <= 1'b0;
        end else if (r_state != HALT) begin
            if (!PCW && !(&r_stallCnt)) begin
                r_stallCnt <= r_stallCnt + 1'b1;
            end
            if (w_freeze) begin
                r_waitCnt <= r_waitCnt + 1'b1;
                if (w_waitLimit) begin
                    r_state      <= HALT;
                    r_memTimeout <= 1'b1;
                end else begin
                    r_state <= MWAIT;
                end
            end else begin
                r_waitCnt <= '0;
                r_state   <= halt_req ? HALT : RUN;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized scoreboard bench for pipe_hazard_ctrl with a rule-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int WAIT_MAX = 16;
    localparam int CNT_W    = 5;
    localparam int STALL_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst, idex_memread, ifid_use_rt, mem_redirect, mem_access, dmem_ready, halt_req;
    logic [4:0] idex_dst, ifid_rs, ifid_rt;
    logic PCW, IFIDW, IDEXW, EXMEMW, MEMWBW, rst1, rst2, rst3, rst4, halted, mem_timeout;
    logic [CNT_W-1:0] stall_cnt;

    typedef struct packed {
        logic [4:0]       w;
        logic [4:0]       wMask;
        logic [3:0]       fl;
        logic             halted;
        logic             timeout;
        logic [CNT_W-1:0] stall;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Reference model state, expressed as plain counters and flags.
    bit mHalted  = 0;
    bit mTimeout = 0;
    int mFreezeRun = 0;
    int mStall   = 0;

    pipe_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .idex_memread(idex_memread), .idex_dst(idex_dst),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_use_rt(ifid_use_rt),
        .mem_redirect(mem_redirect), .mem_access(mem_access), .dmem_ready(dmem_ready),
        .halt_req(halt_req),
        .PCW(PCW), .IFIDW(IFIDW), .IDEXW(IDEXW), .EXMEMW(EXMEMW), .MEMWBW(MEMWBW),
        .rst1(rst1), .rst2(rst2), .rst3(rst3), .rst4(rst4),
        .halted(halted), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input bit r, input bit mr, input bit [4:0] dst,
                                 input bit [4:0] rs, input bit [4:0] rt, input bit useRt,
                                 input bit redir, input bit acc, input bit rdy, input bit hreq);
        exp_t e;
        bit   freeze, loadUse, pcw;
        @(posedge clk);
        #1;
        cycle++;
        rst = r; idex_memread = mr; idex_dst = dst; ifid_rs = rs; ifid_rt = rt;
        ifid_use_rt = useRt; mem_redirect = redir; mem_access = acc; dmem_ready = rdy;
        halt_req = hreq;
        freeze  = acc && !rdy;
        loadUse = mr && dst != 0 && (dst == rs || (useRt && dst == rt));
        e.timeout = mTimeout;
        e.stall   = CNT_W'(mStall);
        e.halted  = 0;
        e.wMask   = 5'b11111;
        if (r) begin
            e.w = 5'b00000; e.fl = 4'b1111;
        end else if (mHalted) begin
            e.w = 5'b00000; e.fl = 4'b0000; e.halted = 1;
        end else if (freeze) begin
            e.w = 5'b00000; e.wMask = 5'b11110; e.fl = 4'b0001;
        end else if (redir) begin
            e.w = 5'b10001; e.wMask = 5'b10001; e.fl = 4'b1110;
        end else if (loadUse) begin
            e.w = 5'b00011; e.wMask = 5'b11011; e.fl = 4'b0100;
        end else begin
            e.w = 5'b11111; e.fl = 4'b0000;
        end
        expQ.push_back(e);
        pcw = e.w[4];
        if (r) begin
            mHalted = 0; mTimeout = 0; mFreezeRun = 0; mStall = 0;
        end else if (!mHalted) begin
            if (!pcw && mStall < STALL_MAX) mStall++;
            if (freeze) begin
                mFreezeRun++;
                if (mFreezeRun == WAIT_MAX) begin
                    mHalted = 1; mTimeout = 1;
                end
            end else begin
                mFreezeRun = 0;
                if (hreq) mHalted = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [4:0] w;
        logic [3:0] fl;
        w  = {PCW, IFIDW, IDEXW, EXMEMW, MEMWBW};
        fl = {rst1, rst2, rst3, rst4};
        checks++;
        if ((w & e.wMask) !== (e.w & e.wMask)) begin
            errors++;
            $display("[TB] FAIL writeEnables cycle %0d: got %b expected %b (mask %b)", cycle, w, e.w, e.wMask);
        end
        checks++;
        if (fl !== e.fl) begin
            errors++;
            $display("[TB] FAIL flushes cycle %0d: got %b expected %b", cycle, fl, e.fl);
        end
        checks++;
        if (halted !== e.halted) begin
            errors++;
            $display("[TB] FAIL halted cycle %0d: got %b expected %b", cycle, halted, e.halted);
        end
        checks++;
        if (mem_timeout !== e.timeout) begin
            errors++;
            $display("[TB] FAIL memTimeout cycle %0d: got %b expected %b", cycle, mem_timeout, e.timeout);
        end
        checks++;
        if (stall_cnt !== e.stall) begin
            errors++;
            $display("[TB] FAIL stallCnt cycle %0d: got %0d expected %0d", cycle, stall_cnt, e.stall);
        end
    endtask

    // Monitor: outputs are valid every cycle, so compare once per cycle when an expectation exists.
    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        int drain;
        rst = 1; idex_memread = 0; idex_dst = 0; ifid_rs = 0; ifid_rt = 0;
        ifid_use_rt = 0; mem_redirect = 0; mem_access = 0; dmem_ready = 1; halt_req = 0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);

        applyStimulus(0, 1, 8, 8, 0, 0, 0, 0, 1, 0);
        idle(1);
        applyStimulus(0, 1, 8, 0, 8, 0, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        applyStimulus(0, 1, 8, 3, 8, 1, 0, 0, 1, 0);
        idle(1);

        applyStimulus(0, 1, 8, 8, 0, 0, 1, 0, 1, 0);
        idle(1);

        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        idle(1);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        applyStimulus(0, 1, 8, 8, 0, 0, 1, 1, 0, 0);
        idle(2);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
        idle(2);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);

        for (int i = 0; i < WAIT_MAX + 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);

        for (int i = 0; i < 800; i++) begin
            bit r;
            bit [4:0] pick [3];
            pick[0] = 5'd0; pick[1] = 5'd8; pick[2] = 5'd9;
            r = ($urandom_range(0, 99) == 0) || (mHalted && $urandom_range(0, 5) == 0);
            applyStimulus(r, $urandom_range(0, 1) == 1,
                          pick[$urandom_range(0, 2)], pick[$urandom_range(0, 2)],
                          pick[$urandom_range(0, 2)], $urandom_range(0, 1) == 1,
                          $urandom_range(0, 5) == 0,
                          $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 49) == 0);
        end

        drain = 0;
        while (expQ.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        @(posedge clk);
        if (expQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage MIPS pipeline. Drives the write enables and synchronous flushes of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It handles load-use hazards, control redirects resolved in MEM, and multi-cycle data-memory waits with a timeout. It also keeps a stall-cycle counter.

Parameters:
WAIT_MAX, 16, maximum consecutive memory-freeze cycles before HALT (≥2)
CNT_W, 16, width of stall_cnt

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
idex_memread  in  1  ID/EX instruction is a load
idex_dst  in  5  ID/EX destination register
ifid_rs  in  5  IF/ID rs field
ifid_rt  in  5  IF/ID rt field
ifid_use_rt  in  1  IF/ID instruction reads rt
mem_redirect  in  1  MEM-stage branch taken or jump (PC loads target)
mem_access  in  1  MEM-stage instruction accesses data memory
dmem_ready  in  1  data memory completes access this cycle
halt_req  in  1  request orderly halt
PCW  out  1  PC write enable
IFIDW  out  1  IF/ID write enable
IDEXW  out  1  ID/EX write enable
EXMEMW  out  1  EX/MEM write enable
MEMWBW  out  1  MEM/WB write enable
rst1  out  1  IF/ID flush
rst2  out  1  ID/EX flush
rst3  out  1  EX/MEM flush
rst4  out  1  MEM/WB flush
halted  out  1  controller in HALT
mem_timeout  out  1  sticky, memory wait exceeded WAIT_MAX
stall_cnt  out  CNT_W  saturating count of cycles with PCW=0 outside HALT

Behaviour:
- State register: RUN, MWAIT, HALT. All pipeline-control outputs are combinational from the current state and inputs, so they take effect at the next clock edge.
- Flush semantics: rstN=1 zeroes the register at the edge and overrides its W.
- rst=1:
  - All W=0 and rst1..rst4=1.
  - Next state RUN; wait_cnt, stall_cnt and mem_timeout are cleared.
  - halted=0.
- Priority within RUN/MWAIT, highest first: freeze, redirect, load-use, normal.
- freeze = mem_access & !dmem_ready:
  - PCW=IFIDW=IDEXW=EXMEMW=0, rst4=1 (bubble into WB), rst1..rst3=0.
  - mem_redirect is ignored during freeze. EX/MEM holds the instruction, so the redirect is re-presented later.
  - wait_cnt increments each freeze cycle and clears on any non-freeze cycle.
  - A freeze cycle with wait_cnt==WAIT_MAX-1 sets next state HALT and mem_timeout=1. A freeze cycle below that limit sets next state MWAIT.
- Redirect (mem_redirect, no freeze):
  - PCW=1, rst1=rst2=rst3=1, MEMWBW=1.
  - This squashes three younger instructions and overrides any load-use.
- Load-use hazard: idex_memread & idex_dst!=0 & (idex_dst==ifid_rs | (ifid_use_rt & idex_dst==ifid_rt)).
  - PCW=IFIDW=0, rst2=1, EXMEMW=MEMWBW=1.
  - Exactly one bubble per hazard, because the load advances.
- Normal: all W=1, all rstN=0.
- Next state from RUN/MWAIT on a non-freeze cycle:
  - HALT if halt_req (the current cycle's outputs are still applied).
  - Otherwise RUN.
- HALT:
  - All W=0, all rstN=0; the pipeline is held intact.
  - halted=1; all inputs are ignored; exit only via rst.
- stall_cnt: increments when PCW=0 and state≠HALT and rst=0; saturates at all-ones.
- mem_timeout: remains 1 until rst.

Test Plan:
- Reset: rst=1 for 2 cycles, then release with idle inputs → during reset all W=0, rst1..4=1; first cycle after, all W=1, rst1..4=0, halted=0, stall_cnt=0.
- Load-use: idex_memread=1, idex_dst=8, ifid_rs=8 for 1 cycle → PCW=0, IFIDW=0, rst2=1, EXMEMW=1; next cycle (idex_memread=0) normal; stall_cnt=1. Repeat with ifid_rt=8, ifid_use_rt=0 → no stall. Repeat with idex_dst=0 → no stall.
- Redirect with simultaneous load-use: mem_redirect=1, load-use true → PCW=1, rst1=rst2=rst3=1, no stall; stall_cnt unchanged.
- Memory wait: mem_access=1, dmem_ready=0 for 3 cycles then 1 → 3 freeze cycles (W=0, rst4=1), then normal; stall_cnt=3, mem_timeout=0, state RUN.
- Timeout: mem_access=1, dmem_ready never, WAIT_MAX=16 → 16 freeze cycles, then halted=1, mem_timeout=1, all outputs 0; rst clears both.
- halt_req during freeze is not honoured until the first non-freeze cycle; halt_req with mem_redirect → redirect outputs that cycle, then HALT.
